// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder block.
package full_adder_pkg;

   // Width used when no WIDTH override is given: a single full-adder cell.
   localparam int unsigned DefaultWidth = 1;

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder. The master drives the operands and the
// slave (the adder) returns the result.
interface full_adder_if
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) ();

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic             in_valid;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             out_valid;

   modport master (
      output a,
      output b,
      output c,
      output in_valid,
      input  sum,
      input  carry,
      input  out_valid
   );

   modport slave (
      input  a,
      input  b,
      input  c,
      input  in_valid,
      output sum,
      output carry,
      output out_valid
   );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full-adder cell, the building block of the ripple chain.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   // Sum is the three-input parity; carry-out is the three-input majority.
   always_comb begin
      sum   = a ^ b ^ c;
      carry = (a & b) | (a & c) | (b & c);
   end

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with an optional registered output stage.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH   = DefaultWidth,
   parameter bit          REG_OUT = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   full_adder_if.slave        bus
);

   // k[i] is the carry into cell i; k[WIDTH] is the final carry-out.
   logic [WIDTH:0]   k;
   logic [WIDTH-1:0] sum_c;

   assign k[0] = bus.c;

   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      fa_cell u_cell (
         .a     (bus.a[gi]),
         .b     (bus.b[gi]),
         .c     (k[gi]),
         .sum   (sum_c[gi]),
         .carry (k[gi+1])
      );
   end

   if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] sum_d, sum_q;
      logic             carry_d, carry_q;
      logic             valid_d, valid_q;

      // Capture every cycle regardless of in_valid; out_valid tells the consumer
      // whether the captured result means anything.
      always_comb begin
         sum_d   = sum_c;
         carry_d = k[WIDTH];
         valid_d = bus.in_valid;
      end

      // Output stage; async reset clears any in-flight result immediately.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
         end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
         end
      end

      assign bus.sum       = sum_q;
      assign bus.carry     = carry_q;
      assign bus.out_valid = valid_q;
   end else begin : g_comb
      // Clock and reset are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign bus.sum       = sum_c;
      assign bus.carry     = k[WIDTH];
      assign bus.out_valid = bus.in_valid;
   end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in 1-, 4- and 8-bit configurations.
module tb_full_adder;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   full_adder_if #(.WIDTH(1)) bus1 ();
   full_adder_if #(.WIDTH(4)) bus4 ();
   full_adder_if #(.WIDTH(8)) bus8 ();

   full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   full_adder #(.WIDTH(4), .REG_OUT(1'b0)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] obs8();
      return {bus8.out_valid, bus8.carry, bus8.sum};
   endfunction

   initial begin
      logic [1:0] tt [8];
      logic [7:0] pa, pb;
      logic       pc, pv;
      logic [8:0] ref9;

      // WIDTH=1 truth table, entries are {sum, carry} indexed by {a, b, c}.
      tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
      tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;

      rst_n = 1'b1;
      bus1.a = '0; bus1.b = '0; bus1.c = 1'b0; bus1.in_valid = 1'b0;
      bus4.a = '0; bus4.b = '0; bus4.c = 1'b0; bus4.in_valid = 1'b0;
      bus8.a = '0; bus8.b = '0; bus8.c = 1'b0; bus8.in_valid = 1'b0;
      pa = '0; pb = '0; pc = 1'b0; pv = 1'b0;

      // Reset asserted before any clock edge.
      #1 rst_n = 1'b0;
      #1 chk("reg_reset_state", obs8(), 10'h000);

      // Exhaustive 1-bit combinational test, run while rst_n is low.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         bus1.a        = v[2];
         bus1.b        = v[1];
         bus1.c        = v[0];
         bus1.in_valid = ~v[0];
         #5;
         chk($sformatf("w1_abc%0b", v), {7'd0, bus1.out_valid, bus1.sum, bus1.carry},
             {7'd0, ~v[0], tt[i]});
      end

      // 4-bit combinational overflow cases.
      bus4.a = 4'hF; bus4.b = 4'h1; bus4.c = 1'b0; bus4.in_valid = 1'b1;
      #5 chk("w4_f_plus_1", {5'd0, bus4.out_valid, bus4.carry, bus4.sum}, 10'h030);
      bus4.a = 4'h7; bus4.b = 4'h8; bus4.c = 1'b1; bus4.in_valid = 1'b0;
      #5 chk("w4_7_plus_8_plus_1", {5'd0, bus4.out_valid, bus4.carry, bus4.sum}, 10'h010);
      bus4.a = 4'h3; bus4.b = 4'h4; bus4.c = 1'b1;
      #5 chk("w4_3_plus_4_plus_1", {5'd0, bus4.out_valid, bus4.carry, bus4.sum}, 10'h008);

      // Registered output holds zero across clock edges while reset is low.
      bus8.a = 8'hAA; bus8.b = 8'h55; bus8.c = 1'b1; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("reg_hold_in_reset", obs8(), 10'h000);

      // Latency test: release reset, present 100+27+1 before edge N.
      @(negedge clk);
      rst_n = 1'b1;
      bus8.a = 8'd100; bus8.b = 8'd27; bus8.c = 1'b1; bus8.in_valid = 1'b1;
      #1 chk("lat_before_edge", obs8(), 10'h000);
      @(posedge clk); #1;
      chk("lat_after_edge", obs8(), {1'b1, 1'b0, 8'd128});

      // Max operands: 255+255+1 = 511.
      @(negedge clk);
      bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 1'b1; bus8.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("w8_max_invalid", obs8(), {1'b0, 1'b1, 8'hFF});

      // Load a valid result, then reset between edges.
      @(negedge clk);
      bus8.a = 8'd1; bus8.b = 8'd2; bus8.c = 1'b0; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("pre_reset_valid", obs8(), {1'b1, 1'b0, 8'd3});
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_now", obs8(), 10'h000);
      bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c = 1'b0; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("reset_discards", obs8(), 10'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_after_release", obs8(), {1'b1, 1'b1, 8'h00});

      // Random pipeline test against an arithmetic reference.
      for (int i = 0; i <= 1000; i++) begin
         @(negedge clk);
         if (i > 0) begin
            ref9 = {1'b0, pa} + {1'b0, pb} + {8'd0, pc};
            chk($sformatf("rand_%0d", i), obs8(), {pv, ref9});
         end
         pa = 8'($urandom);
         pb = 8'($urandom);
         pc = 1'($urandom);
         pv = 1'($urandom);
         bus8.a = pa; bus8.b = pb; bus8.c = pc; bus8.in_valid = pv;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
